// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode/funct codes and mul/div FSM state encoding for alu_muldiv
package alu_pkg;

  localparam logic [5:0] OP_SLL   = 6'b000000;
  localparam logic [5:0] OP_SRL   = 6'b000010;
  localparam logic [5:0] OP_SRA   = 6'b000011;
  localparam logic [5:0] OP_SLLV  = 6'b000100;
  localparam logic [5:0] OP_SRLV  = 6'b000110;
  localparam logic [5:0] OP_SRAV  = 6'b000111;
  localparam logic [5:0] OP_MFHI  = 6'b010000;
  localparam logic [5:0] OP_MTHI  = 6'b010001;
  localparam logic [5:0] OP_MFLO  = 6'b010010;
  localparam logic [5:0] OP_MTLO  = 6'b010011;
  localparam logic [5:0] OP_MULT  = 6'b011000;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_DIV   = 6'b011010;
  localparam logic [5:0] OP_DIVU  = 6'b011011;
  localparam logic [5:0] OP_ADD   = 6'b100000;
  localparam logic [5:0] OP_ADDU  = 6'b100001;
  localparam logic [5:0] OP_SUB   = 6'b100010;
  localparam logic [5:0] OP_SUBU  = 6'b100011;
  localparam logic [5:0] OP_AND   = 6'b100100;
  localparam logic [5:0] OP_OR    = 6'b100101;
  localparam logic [5:0] OP_XOR   = 6'b100110;
  localparam logic [5:0] OP_NOR   = 6'b100111;
  localparam logic [5:0] OP_SLT   = 6'b101010;
  localparam logic [5:0] OP_SLTU  = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_IDLE  = 6'b111111;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX} md_state_t;

endpackage

// File: rtl/alu_muldiv_if.sv
// rtl/alu_muldiv_if.sv - request/result bundle between the EX-stage requester and alu_muldiv
interface alu_muldiv_if #(
  parameter int NB_DATA  = 32,
  parameter int NB_OP    = 6,
  parameter int NB_SHAMT = 5
) ();
  logic                i_valid;
  logic                o_ready;
  logic [NB_OP-1:0]    i_opcode;
  logic [NB_DATA-1:0]  i_operand1;
  logic [NB_DATA-1:0]  i_operand2;
  logic [NB_SHAMT-1:0] i_shamt;
  logic [NB_DATA-1:0]  o_result;
  logic                o_valid;
  logic                o_md_done;
  logic [NB_DATA-1:0]  o_hi;
  logic [NB_DATA-1:0]  o_lo;

  modport master (
    output i_valid, i_opcode, i_operand1, i_operand2, i_shamt,
    input  o_ready, o_result, o_valid, o_md_done, o_hi, o_lo
  );

  modport slave (
    input  i_valid, i_opcode, i_operand1, i_operand2, i_shamt,
    output o_ready, o_result, o_valid, o_md_done, o_hi, o_lo
  );
endinterface

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - one-bit-per-cycle shift-add multiply / restoring divide on magnitudes, sign fix in FIX
module muldiv_seq
  import alu_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_CNT  = 5
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_div,
  input  logic               i_signed,
  input  logic [NB_DATA-1:0] i_a,
  input  logic [NB_DATA-1:0] i_b,
  output logic               o_idle,
  output logic               o_done,
  output logic [NB_DATA-1:0] o_hi,
  output logic [NB_DATA-1:0] o_lo
);
  md_state_t           r_state;
  logic [NB_CNT-1:0]   r_cnt;
  logic [NB_DATA-1:0]  r_hi, r_lo, r_b;
  logic                r_div, r_neg_lo, r_neg_hi, r_dz;

  logic                w_a_neg, w_b_neg;
  logic [NB_DATA-1:0]  w_a_mag, w_b_mag;
  logic [NB_DATA:0]    w_sum, w_shl, w_diff;
  logic [2*NB_DATA-1:0] w_prod_fix;

  assign w_a_neg = i_signed && i_a[NB_DATA-1];
  assign w_b_neg = i_signed && i_b[NB_DATA-1];
  assign w_a_mag = w_a_neg ? -i_a : i_a;
  assign w_b_mag = w_b_neg ? -i_b : i_b;

  // r_hi is the running high product half (MUL) or partial remainder (DIV)
  assign w_sum  = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_b : '0)};
  assign w_shl  = {r_hi, r_lo[NB_DATA-1]};
  assign w_diff = w_shl - {1'b0, r_b};

  assign w_prod_fix = r_neg_lo ? -{r_hi, r_lo} : {r_hi, r_lo};

  assign o_idle = (r_state == ST_IDLE);
  assign o_done = (r_state == ST_FIX);

  always_comb begin
    o_hi = w_prod_fix[2*NB_DATA-1:NB_DATA];
    o_lo = w_prod_fix[NB_DATA-1:0];
    if (r_div) begin
      o_hi = r_neg_hi ? -r_hi : r_hi;
      o_lo = r_dz ? '1 : (r_neg_lo ? -r_lo : r_lo);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_div    <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_dz     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state  <= i_div ? ST_DIV : ST_MUL;
            r_cnt    <= NB_CNT'(NB_DATA - 1);
            r_hi     <= '0;
            r_lo     <= i_div ? w_a_mag : w_b_mag;
            r_b      <= i_div ? w_b_mag : w_a_mag;
            r_div    <= i_div;
            r_neg_lo <= w_a_neg ^ w_b_neg;
            r_neg_hi <= w_a_neg;
            r_dz     <= (i_b == '0);
          end
        end
        ST_MUL: {r_hi, r_lo} <= {w_sum, r_lo[NB_DATA-1:1]};
        ST_DIV: begin
          if (!w_diff[NB_DATA]) begin
            r_hi <= w_diff[NB_DATA-1:0];
            r_lo <= {r_lo[NB_DATA-2:0], 1'b1};
          end else begin
            r_hi <= w_shl[NB_DATA-1:0];
            r_lo <= {r_lo[NB_DATA-2:0], 1'b0};
          end
        end
        ST_FIX:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
      if (r_state == ST_MUL || r_state == ST_DIV) begin
        if (r_cnt == '0) r_state <= ST_FIX;
        else             r_cnt   <= r_cnt - 1'b1;
      end
    end
  end
endmodule

// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - registered EX-stage ALU with HI/LO and mul/div; ALU_FAST_MULT_EN selects a one-cycle multiplier
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int NB_DATA  = 32,
  parameter int NB_OP    = 6,
  parameter int NB_SHAMT = 5
) (
  input  logic         i_clk,
  input  logic         i_reset,
  alu_muldiv_if.slave  bus
);
  logic [NB_DATA-1:0]   r_result, r_hi, r_lo;
  logic                 r_valid, r_md_done;

  logic [NB_OP-1:0]     w_op;
  logic [NB_DATA-1:0]   w_a, w_b, w_res, w_seq_hi, w_seq_lo;
  logic [NB_SHAMT-1:0]  w_vsh;
  logic                 w_accept, w_res_valid, w_is_mul, w_is_div, w_is_signed;
  logic                 w_seq_start, w_seq_idle, w_seq_done, w_fast_mul;
  logic [2*NB_DATA-1:0] w_prod;

  assign w_op        = bus.i_opcode;
  assign w_a         = bus.i_operand1;
  assign w_b         = bus.i_operand2;
  assign w_vsh       = w_b[NB_SHAMT-1:0];
  assign w_accept    = bus.i_valid && w_seq_idle;
  assign w_is_mul    = (w_op == OP_MULT) || (w_op == OP_MULTU);
  assign w_is_div    = (w_op == OP_DIV)  || (w_op == OP_DIVU);
  assign w_is_signed = (w_op == OP_MULT) || (w_op == OP_DIV);

`ifdef ALU_FAST_MULT_EN
  logic [2*NB_DATA-1:0] w_ext_a, w_ext_b;
  assign w_ext_a     = w_is_signed ? {{NB_DATA{w_a[NB_DATA-1]}}, w_a} : {{NB_DATA{1'b0}}, w_a};
  assign w_ext_b     = w_is_signed ? {{NB_DATA{w_b[NB_DATA-1]}}, w_b} : {{NB_DATA{1'b0}}, w_b};
  assign w_prod      = w_ext_a * w_ext_b;
  assign w_fast_mul  = w_accept && w_is_mul;
  assign w_seq_start = w_accept && w_is_div;
`else
  assign w_prod      = '0;
  assign w_fast_mul  = 1'b0;
  assign w_seq_start = w_accept && (w_is_mul || w_is_div);
`endif

  muldiv_seq #(.NB_DATA(NB_DATA), .NB_CNT(NB_SHAMT)) u_seq (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_start  (w_seq_start),
    .i_div    (w_is_div),
    .i_signed (w_is_signed),
    .i_a      (w_a),
    .i_b      (w_b),
    .o_idle   (w_seq_idle),
    .o_done   (w_seq_done),
    .o_hi     (w_seq_hi),
    .o_lo     (w_seq_lo)
  );

  always_comb begin
    w_res       = '0;
    w_res_valid = 1'b1;
    case (w_op)
      OP_SLL:                             w_res = w_a << bus.i_shamt;
      OP_SRL:                             w_res = w_a >> bus.i_shamt;
      OP_SRA:                             w_res = $signed(w_a) >>> bus.i_shamt;
      OP_SLLV:                            w_res = w_a << w_vsh;
      OP_SRLV:                            w_res = w_a >> w_vsh;
      OP_SRAV:                            w_res = $signed(w_a) >>> w_vsh;
      OP_ADD, OP_ADDU, OP_ADDI, OP_ADDIU: w_res = w_a + w_b;
      OP_SUB, OP_SUBU:                    w_res = w_a - w_b;
      OP_AND, OP_ANDI:                    w_res = w_a & w_b;
      OP_OR, OP_ORI:                      w_res = w_a | w_b;
      OP_XOR, OP_XORI:                    w_res = w_a ^ w_b;
      OP_NOR:                             w_res = ~(w_a | w_b);
      OP_SLT, OP_SLTI:   w_res = {{(NB_DATA-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
      OP_SLTU, OP_SLTIU: w_res = {{(NB_DATA-1){1'b0}}, (w_a < w_b)};
      OP_LUI:            w_res = {w_b[NB_DATA/2-1:0], {(NB_DATA/2){1'b0}}};
      OP_MFHI:           w_res = r_hi;
      OP_MFLO:           w_res = r_lo;
      default:           w_res_valid = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_result  <= '0;
      r_valid   <= 1'b0;
      r_md_done <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_valid   <= w_accept && w_res_valid;
      r_md_done <= w_seq_done || w_fast_mul;
      if (w_accept) r_result <= w_res;
      // MT*/fast-mul can only be accepted while the sequencer is idle, so never collide with FIX
      if (w_seq_done)                       {r_hi, r_lo} <= {w_seq_hi, w_seq_lo};
      else if (w_fast_mul)                  {r_hi, r_lo} <= w_prod;
      else if (w_accept && w_op == OP_MTHI) r_hi <= w_a;
      else if (w_accept && w_op == OP_MTLO) r_lo <= w_a;
    end
  end

  assign bus.o_ready   = w_seq_idle;
  assign bus.o_result  = r_result;
  assign bus.o_valid   = r_valid;
  assign bus.o_md_done = r_md_done;
  assign bus.o_hi      = r_hi;
  assign bus.o_lo      = r_lo;
endmodule

// File: tb/tb_alu_muldiv.sv
// tb/tb_alu_muldiv.sv - directed self-checking bench for alu_muldiv (honours ALU_FAST_MULT_EN)
module tb_alu_muldiv;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_err    = 0;

`ifdef ALU_FAST_MULT_EN
  localparam int MUL_LAT = 0;
`else
  localparam int MUL_LAT = 33;
`endif

  always #5 clk = ~clk;

  alu_muldiv_if #(.NB_DATA(32), .NB_OP(6), .NB_SHAMT(5)) bus ();

  alu_muldiv #(.NB_DATA(32), .NB_OP(6), .NB_SHAMT(5)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh);
    bus.i_opcode   = op;
    bus.i_operand1 = a;
    bus.i_operand2 = b;
    bus.i_shamt    = sh;
    bus.i_valid    = 1'b1;
  endtask

  task automatic simple(input string tag, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh, input logic [31:0] exp);
    drive(op, a, b, sh);
    tick();
    bus.i_valid = 1'b0;
    chk({tag, ".valid"}, 64'(bus.o_valid), 64'd1);
    chk({tag, ".result"}, 64'(bus.o_result), 64'(exp));
    tick();
    chk({tag, ".pulse"}, 64'(bus.o_valid), 64'd0);
  endtask

  task automatic md_op(input string tag, input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_hi,
                       input logic [31:0] exp_lo, input int exp_low);
    int low  = 0;
    int seen = 0;
    drive(op, a, b, 5'd0);
    tick();
    bus.i_valid    = 1'b0;
    bus.i_operand1 = 32'h5A5A_A5A5;
    bus.i_operand2 = 32'h0000_0003;
    while (!bus.o_ready && low < 100) begin
      if (bus.o_md_done) seen++;
      tick();
      low++;
    end
    chk({tag, ".busy_cycles"}, 64'(low), 64'(exp_low));
    chk({tag, ".early_done"}, 64'(seen), 64'd0);
    chk({tag, ".md_done"}, 64'(bus.o_md_done), 64'd1);
    chk({tag, ".hi"}, 64'(bus.o_hi), 64'(exp_hi));
    chk({tag, ".lo"}, 64'(bus.o_lo), 64'(exp_lo));
    tick();
    chk({tag, ".done_pulse"}, 64'(bus.o_md_done), 64'd0);
  endtask

  initial begin
    int k;
    int dn;
    rst = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_opcode = OP_IDLE;
    bus.i_operand1 = '0;
    bus.i_operand2 = '0;
    bus.i_shamt = '0;
    tick();
    tick();
    chk("rst.result", 64'(bus.o_result), 64'd0);
    chk("rst.valid", 64'(bus.o_valid), 64'd0);
    chk("rst.md_done", 64'(bus.o_md_done), 64'd0);
    chk("rst.hi", 64'(bus.o_hi), 64'd0);
    chk("rst.lo", 64'(bus.o_lo), 64'd0);
    chk("rst.ready", 64'(bus.o_ready), 64'd1);
    rst = 1'b0;
    tick();

    simple("addu_wrap", OP_ADDU, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0);
    simple("slt", OP_SLT, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h1);
    simple("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0);
    simple("srav", OP_SRAV, 32'h8000_0000, 32'd36, 5'd0, 32'hF800_0000);
    simple("lui", OP_LUI, 32'h0, 32'hABCD_1234, 5'd0, 32'h1234_0000);
    simple("subu", OP_SUBU, 32'h0, 32'h1, 5'd0, 32'hFFFF_FFFF);
    simple("sll", OP_SLL, 32'h1, 32'h0, 5'd31, 32'h8000_0000);
    simple("nor", OP_NOR, 32'h0F0F_0000, 32'h0000_00F0, 5'd0, 32'hF0F0_FF0F);

    drive(6'b110000, 32'h1234, 32'h5678, 5'd0);
    tick();
    bus.i_valid = 1'b0;
    chk("unknown.valid", 64'(bus.o_valid), 64'd0);
    chk("unknown.result", 64'(bus.o_result), 64'd0);
    drive(OP_IDLE, 32'h1, 32'h1, 5'd0);
    tick();
    bus.i_valid = 1'b0;
    chk("idle.valid", 64'(bus.o_valid), 64'd0);

    md_op("mult", OP_MULT, 32'hFFFF_FFFE, 32'h3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MUL_LAT);
    simple("mflo", OP_MFLO, 32'h0, 32'h0, 5'd0, 32'hFFFF_FFFA);
    md_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, MUL_LAT);
    md_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    md_op("divu_zero", OP_DIVU, 32'h7, 32'h0, 32'h7, 32'hFFFF_FFFF, 33);
    md_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33);

    drive(OP_MTHI, 32'hDEAD_BEEF, 32'h0, 5'd0);
    tick();
    bus.i_valid = 1'b0;
    chk("mthi.valid", 64'(bus.o_valid), 64'd0);
    chk("mthi.hi", 64'(bus.o_hi), 64'hDEAD_BEEF);
    drive(OP_MTLO, 32'h1234_5678, 32'h0, 5'd0);
    tick();
    bus.i_valid = 1'b0;
    chk("mtlo.lo", 64'(bus.o_lo), 64'h1234_5678);

    // MFHI is held on the request lines for the whole DIV and must see the new HI
    drive(OP_DIV, 32'd100, 32'd7, 5'd0);
    tick();
    drive(OP_MFHI, 32'h0, 32'h0, 5'd0);
    k = 1;
    while (!bus.o_valid && k < 100) begin
      tick();
      k++;
    end
    bus.i_valid = 1'b0;
    chk("mfhi_held.cycles", 64'(k), 64'd35);
    chk("mfhi_held.result", 64'(bus.o_result), 64'd2);
    chk("mfhi_held.lo", 64'(bus.o_lo), 64'd14);
    tick();
    chk("mfhi_held.once", 64'(bus.o_valid), 64'd0);

    drive(OP_MULTU, 32'd5, 32'd7, 5'd0);
    tick();
    bus.i_valid = 1'b0;
    repeat (10) tick();
    chk("abort.busy", 64'(bus.o_ready), 64'(MUL_LAT == 0));
    rst = 1'b1;
    tick();
    chk("abort.ready", 64'(bus.o_ready), 64'd1);
    chk("abort.hi", 64'(bus.o_hi), 64'd0);
    chk("abort.lo", 64'(bus.o_lo), 64'd0);
    chk("abort.md_done", 64'(bus.o_md_done), 64'd0);
    rst = 1'b0;
    dn = 0;
    repeat (40) begin
      tick();
      if (bus.o_md_done) dn++;
    end
    chk("abort.no_done", 64'(dn), 64'd0);
    chk("abort.hi_after", 64'(bus.o_hi), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
